// File: rtl/bloom_pkg.sv
// Shared types and hash constants for the K-hash Bloom filter.
package bloom_pkg;

  typedef enum logic [1:0] {
    OP_INS = 2'b00,
    OP_QRY = 2'b01,
    OP_CLR = 2'b10,
    OP_RSV = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HASH = 2'd1,
    CLR  = 2'd2,
    RESP = 2'd3
  } state_e;

  localparam logic [31:0] HASH_C0 = 32'h9E3779B1;
  localparam logic [31:0] HASH_C1 = 32'h85EBCA77;
  localparam logic [31:0] HASH_C2 = 32'hC2B2AE3D;
  localparam logic [31:0] HASH_C3 = 32'h27D4EB2F;

  // Multiplier for hash function j.
  function automatic logic [31:0] hash_c(input logic [1:0] j);
    case (j)
      2'd0:    return HASH_C0;
      2'd1:    return HASH_C1;
      2'd2:    return HASH_C2;
      default: return HASH_C3;
    endcase
  endfunction

endpackage

// File: rtl/bloom_hash.sv
// Multiplicative hash: index j of a key is the top MW bits of key * HASH_C[j] mod 2^32.
module bloom_hash #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned MW     = 6
) (
  input  logic [DATA_W-1:0] key_i,
  input  logic [1:0]        j_i,
  output logic [MW-1:0]     idx_o
);
  import bloom_pkg::*;

  logic [31:0] prod_c;

  assign prod_c = 32'(key_i) * hash_c(j_i);
  assign idx_o  = MW'(prod_c >> (32 - MW));

endmodule

// File: rtl/bloom_filter_k.sv
// K-hash Bloom filter with insert/query/clear over valid/ready and a one-cycle hit strobe.
// Optional occupancy/insert statistics ports are enabled by defining BLOOM_STATS_EN.
module bloom_filter_k #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned M      = 64,
  parameter int unsigned K      = 3,
  localparam int unsigned MW    = $clog2(M)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [DATA_W-1:0] req_data,
  output logic              rsp_valid,
  output logic              rsp_hit,
  output logic [M-1:0]      filter_bits
`ifdef BLOOM_STATS_EN
  ,
  output logic [MW:0]       pop_cnt,
  output logic [15:0]       ins_cnt
`endif
);
  import bloom_pkg::*;

  localparam logic [1:0] J_LAST = 2'(K - 1);

  state_e              state_q;
  op_e                 op_q;
  op_e                 req_op_c;
  logic [DATA_W-1:0]   key_q;
  logic [1:0]          j_q;
  logic                acc_q;
  logic [M-1:0]        arr_q;
  logic [MW-1:0]       idx_c;
  logic                bit_c;

  assign req_op_c    = op_e'(req_op);
  assign filter_bits = arr_q;
  assign bit_c       = arr_q[idx_c];

  // Single hash unit, stepped through j = 0..K-1 during HASH.
  bloom_hash #(
    .DATA_W (DATA_W),
    .MW     (MW)
  ) u_hash (
    .key_i (key_q),
    .j_i   (j_q),
    .idx_o (idx_c)
  );

  // Control FSM, array and response registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      op_q      <= OP_INS;
      key_q     <= '0;
      j_q       <= 2'd0;
      acc_q     <= 1'b0;
      arr_q     <= '0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_hit   <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      rsp_hit   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            key_q     <= req_data;
            op_q      <= req_op_c;
            acc_q     <= 1'b1;
            j_q       <= 2'd0;
            req_ready <= 1'b0;
            state_q   <= (req_op_c == OP_INS || req_op_c == OP_QRY) ? HASH : CLR;
          end
        end
        HASH: begin
          // Read happens before the write, so a fresh bit reports a miss.
          acc_q <= acc_q & bit_c;
          if (op_q == OP_INS) begin
            arr_q[idx_c] <= 1'b1;
          end
          if (j_q == J_LAST) begin
            j_q       <= 2'd0;
            state_q   <= RESP;
            rsp_valid <= 1'b1;
            rsp_hit   <= acc_q & bit_c;
          end else begin
            j_q <= j_q + 2'd1;
          end
        end
        CLR: begin
          if (op_q == OP_CLR) begin
            arr_q <= '0;
          end
          acc_q     <= 1'b0;
          state_q   <= RESP;
          rsp_valid <= 1'b1;
          rsp_hit   <= 1'b0;
        end
        RESP: begin
          state_q   <= IDLE;
          req_ready <= 1'b1;
        end
        default: begin
          state_q   <= IDLE;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

`ifdef BLOOM_STATS_EN
  localparam logic [MW:0] POP_ONE = (MW+1)'(1);

  // Population counts only genuine 0->1 transitions; inserts count at accept.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pop_cnt <= '0;
      ins_cnt <= 16'd0;
    end else begin
      if (state_q == CLR && op_q == OP_CLR) begin
        pop_cnt <= '0;
        ins_cnt <= 16'd0;
      end else begin
        if (state_q == HASH && op_q == OP_INS && !bit_c) begin
          pop_cnt <= pop_cnt + POP_ONE;
        end
        if (state_q == IDLE && req_valid && req_op_c == OP_INS && ins_cnt != 16'hFFFF) begin
          ins_cnt <= ins_cnt + 16'd1;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_bloom_filter_k.sv
// Scoreboard bench for bloom_filter_k: driver pushes model predictions, monitor checks responses.
module tb_bloom_filter_k;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned M      = 64;
  localparam int unsigned K      = 3;
  localparam int unsigned MW     = $clog2(M);
  localparam int          BOUND  = 50;

  logic              clk       = 1'b0;
  logic              rst       = 1'b0;
  logic              req_valid = 1'b0;
  logic [1:0]        req_op    = 2'd0;
  logic [DATA_W-1:0] req_data  = '0;
  logic              req_ready;
  logic              rsp_valid;
  logic              rsp_hit;
  logic [M-1:0]      filter_bits;
`ifdef BLOOM_STATS_EN
  logic [MW:0]       pop_cnt;
  logic [15:0]       ins_cnt;
`endif

  always #5 clk = ~clk;

  bloom_filter_k #(.DATA_W(DATA_W), .M(M), .K(K)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_op      (req_op),
    .req_data    (req_data),
    .rsp_valid   (rsp_valid),
    .rsp_hit     (rsp_hit),
    .filter_bits (filter_bits)
`ifdef BLOOM_STATS_EN
    ,
    .pop_cnt     (pop_cnt),
    .ins_cnt     (ins_cnt)
`endif
  );

  typedef struct {
    logic         hit;
    logic [M-1:0] bits;
    int           lat;
    int           acc;
    int unsigned  pop;
    int unsigned  ins;
  } exp_t;

  exp_t        sb[$];
  int          cyc = 0;
  int          n_tests = 0;
  int          n_fail = 0;
  bit          mdl[M];
  int unsigned mdl_ins = 0;
  int unsigned hc[4] = '{32'h9E3779B1, 32'h85EBCA77, 32'hC2B2AE3D, 32'h27D4EB2F};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference index: top MW bits of the 32-bit product.
  function automatic int unsigned idx_of(input int unsigned key, input int j);
    longint unsigned p;
    p = (longint'(key) * longint'(hc[j])) % 64'h1_0000_0000;
    return int'(p >> (32 - MW));
  endfunction

  function automatic logic [M-1:0] mdl_vec();
    logic [M-1:0] v;
    for (int i = 0; i < M; i++) v[i] = mdl[i];
    return v;
  endfunction

  function automatic int unsigned mdl_pop();
    int unsigned n = 0;
    for (int i = 0; i < M; i++) n += mdl[i];
    return n;
  endfunction

  task automatic mdl_clear();
    for (int i = 0; i < M; i++) mdl[i] = 1'b0;
    mdl_ins = 0;
  endtask

  // Apply one accepted request to the model and queue the expected response.
  task automatic model_op(input logic [1:0] op, input logic [DATA_W-1:0] key, input int acc);
    exp_t e;
    logic hit;
    hit = 1'b1;
    if (op == 2'b00 || op == 2'b01) begin
      if (op == 2'b00 && mdl_ins < 16'hFFFF) mdl_ins++;
      for (int j = 0; j < K; j++) begin
        hit = hit & mdl[idx_of(32'(key), j)];
        if (op == 2'b00) mdl[idx_of(32'(key), j)] = 1'b1;
      end
      e.lat = K;
    end else begin
      if (op == 2'b10) mdl_clear();
      hit   = 1'b0;
      e.lat = 1;
    end
    e.hit  = hit;
    e.bits = mdl_vec();
    e.acc  = acc;
    e.pop  = mdl_pop();
    e.ins  = mdl_ins;
    sb.push_back(e);
  endtask

  // Monitor: every response strobe must match the oldest prediction.
  always @(negedge clk) begin
    if (rst && rsp_valid) begin
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_rsp: rsp_valid=1 with no request outstanding (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("rsp_hit", 64'(rsp_hit), 64'(e.hit));
        chk("filter_bits", 64'(filter_bits), 64'(e.bits));
        chk("latency", 64'(cyc - e.acc), 64'(e.lat));
`ifdef BLOOM_STATS_EN
        chk("pop_cnt", 64'(pop_cnt), 64'(e.pop));
        chk("ins_cnt", 64'(ins_cnt), 64'(e.ins));
`endif
      end
    end
  end

  task automatic do_op(input logic [1:0] op, input logic [DATA_W-1:0] key, input bit hold);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!req_ready && guard < BOUND) begin
      @(negedge clk);
      guard++;
    end
    if (!req_ready) begin
      $display("FAIL ready_timeout: req_ready stuck low before issue");
      $fatal(1, "[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    end
    req_valid = 1'b1;
    req_op    = op;
    req_data  = key;
    @(posedge clk);
    #1;
    model_op(op, key, cyc);
    chk("ready_low_after_accept", 64'(req_ready), 64'(0));
    if (!hold) req_valid = 1'b0;
    guard = 0;
    @(negedge clk);
    while (!req_ready && guard < BOUND) begin
      if (hold) begin
        req_op   = 2'($urandom);
        req_data = DATA_W'($urandom);
      end
      @(negedge clk);
      guard++;
    end
    req_valid = 1'b0;
    chk("op_complete", 64'(req_ready), 64'(1));
  endtask

  initial begin
    mdl_clear();
    #12;
    chk("reset_ready", 64'(req_ready), 64'(1));
    chk("reset_rsp_valid", 64'(rsp_valid), 64'(0));
    chk("reset_rsp_hit", 64'(rsp_hit), 64'(0));
    chk("reset_bits", 64'(filter_bits), 64'(0));
    @(negedge clk);
    rst = 1'b1;

    do_op(2'b00, 8'h00, 1'b0);
    chk("bits_after_ins0", 64'(filter_bits), 64'h1);
    do_op(2'b01, 8'h00, 1'b0);
    do_op(2'b01, 8'h01, 1'b0);
    do_op(2'b00, 8'h01, 1'b0);
    do_op(2'b00, 8'h01, 1'b1);
    chk("bits_after_ins1", 64'(filter_bits),
        (64'h1 << 0) | (64'h1 << 33) | (64'h1 << 39) | (64'h1 << 48));
`ifdef BLOOM_STATS_EN
    chk("pop_cnt_directed", 64'(pop_cnt), 64'd4);
    chk("ins_cnt_directed", 64'(ins_cnt), 64'd3);
`endif
    do_op(2'b11, 8'h22, 1'b0);
    do_op(2'b10, 8'h00, 1'b0);
    chk("bits_after_clear", 64'(filter_bits), 64'h0);
`ifdef BLOOM_STATS_EN
    chk("pop_cnt_clear", 64'(pop_cnt), 64'd0);
    chk("ins_cnt_clear", 64'(ins_cnt), 64'd0);
`endif
    do_op(2'b01, 8'h00, 1'b0);

    // Reset in the middle of an insert with req_valid held: no response, array zeroed.
    do_op(2'b00, 8'h07, 1'b0);
    @(negedge clk);
    req_valid = 1'b1;
    req_op    = 2'b00;
    req_data  = 8'h05;
    @(posedge clk);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("rst_mid_bits", 64'(filter_bits), 64'h0);
    chk("rst_mid_ready", 64'(req_ready), 64'(1));
    chk("rst_mid_rsp_valid", 64'(rsp_valid), 64'(0));
`ifdef BLOOM_STATS_EN
    chk("rst_mid_pop", 64'(pop_cnt), 64'd0);
    chk("rst_mid_ins", 64'(ins_cnt), 64'd0);
`endif
    req_valid = 1'b0;
    mdl_clear();
    @(negedge clk);
    rst = 1'b1;
    repeat (6) @(negedge clk);

    for (int n = 0; n < 150; n++) begin
      int          r;
      logic [1:0]  op;
      r  = int'($urandom_range(0, 9));
      op = (r < 5) ? 2'b00 : (r < 8) ? 2'b01 : (r == 8) ? 2'b10 : 2'b11;
      do_op(op, DATA_W'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
    end

    repeat (K + 4) @(negedge clk);
    chk("scoreboard_drained", 64'(sb.size()), 64'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
